// File: rtl/dp_ctrl_pkg.sv
// Shared types, opcode constants and instruction field positions for the
// dp_control block and its hazard unit.
package dp_ctrl_pkg;

   localparam int XLEN     = 32;
   localparam int REG_BITS = 5;

   localparam logic [6:0] OP_ADD  = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;

   localparam int OPC_MSB = 6;
   localparam int OPC_LSB = 0;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 7;
   localparam int RS1_MSB = 19;
   localparam int RS1_LSB = 15;
   localparam int RS2_MSB = 24;
   localparam int RS2_LSB = 20;
   localparam int IMM_MSB = 31;
   localparam int IMM_LSB = 20;

   // One pipe stage of write-back control; v means "this entry will write rd".
   typedef struct packed {
      logic                v;
      logic [REG_BITS-1:0] rd;
      logic                f;
   } stage_t;

   function automatic logic [XLEN-1:0] sext12(input logic [11:0] x);
      return {{(XLEN-12){x[11]}}, x};
   endfunction

endpackage

// File: rtl/dp_hazard_unit.sv
// Read-after-write detector: flags a DEC-stage source that is still pending
// write-back in the ALU or WR stage (no bypass, no regfile write-through).
module dp_hazard_unit
   import dp_ctrl_pkg::*;
(
   input  logic                inst_valid,
   input  logic                legal,
   input  logic                use_a,
   input  logic                use_b,
   input  logic [REG_BITS-1:0] addr_a,
   input  logic [REG_BITS-1:0] addr_b,
   input  stage_t              alu_s,
   input  stage_t              wr_s,
   output logic                hazard
);

   function automatic logic pending(input logic [REG_BITS-1:0] s,
                                    input stage_t a, input stage_t w);
      return (s != '0) && ((a.v && (a.rd == s)) || (w.v && (w.rd == s)));
   endfunction

   logic hit_a;
   logic hit_b;

   assign hit_a  = use_a && pending(addr_a, alu_s, wr_s);
   assign hit_b  = use_b && pending(addr_b, alu_s, wr_s);
   assign hazard = inst_valid && legal && (hit_a || hit_b);

endmodule

// File: rtl/dp_control.sv
// Control unit for the DEC -> ALU -> WR datapath: decode, issue handshake,
// write-back control pipe, RAW stall and activity counters.
module dp_control
   import dp_ctrl_pkg::*;
#(
   parameter int LENGTH   = 32,
   parameter int NREGS    = 32,
   parameter int SEL_BITS = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [LENGTH-1:0]   inst,
   input  logic                inst_valid,
   output logic                inst_ready,
   output logic [SEL_BITS-1:0] addr_a,
   output logic [SEL_BITS-1:0] addr_b,
   output logic [LENGTH-1:0]   imm,
   output logic                f,
   output logic                f_alu,
   output logic [SEL_BITS-1:0] addr_d,
   output logic                wr_regfile,
   output logic                illegal,
   output logic [31:0]         issued_cnt,
   output logic [31:0]         stall_cnt
);

   logic [6:0]          opcode;
   logic [REG_BITS-1:0] rd;
   logic                is_add;
   logic                is_addi;
   logic                legal;
   logic                hazard;
   logic                transfer;
   stage_t              issue_s;
   stage_t              alu_q;
   stage_t              wr_q;
   logic                illegal_q;
   logic                unused_bits;

   assign opcode  = inst[OPC_MSB:OPC_LSB];
   assign rd      = inst[RD_MSB:RD_LSB];
   assign is_add  = (opcode == OP_ADD);
   assign is_addi = (opcode == OP_ADDI);
   assign legal   = is_add || is_addi;

   // DEC outputs follow inst every cycle, independent of inst_valid.
   assign addr_a = inst[RS1_MSB:RS1_LSB];
   assign addr_b = inst[RS2_MSB:RS2_LSB];
   assign imm    = sext12(inst[IMM_MSB:IMM_LSB]);
   assign f      = is_addi;

   // ADDI reuses the rs2 field as immediate bits, so only ADD checks source B.
   dp_hazard_unit u_hazard (
      .inst_valid (inst_valid),
      .legal      (legal),
      .use_a      (1'b1),
      .use_b      (is_add),
      .addr_a     (addr_a),
      .addr_b     (addr_b),
      .alu_s      (alu_q),
      .wr_s       (wr_q),
      .hazard     (hazard)
   );

   assign inst_ready = !hazard;
   assign transfer   = inst_valid && inst_ready;

   // NOTE: every field gets a default before the conditional update so no latch is inferred.
   always_comb begin
      issue_s = '0;
      if (transfer) begin
         issue_s.v  = legal && (rd != '0);
         issue_s.rd = rd;
         issue_s.f  = is_addi;
      end
   end

   // NOTE: state updates use non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_q      <= '0;
         wr_q       <= '0;
         illegal_q  <= 1'b0;
         issued_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         alu_q     <= issue_s;
         wr_q      <= alu_q;
         illegal_q <= transfer && !legal;
         if (transfer)
            issued_cnt <= issued_cnt + 32'd1;
         if (inst_valid && !inst_ready)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign wr_regfile = wr_q.v;
   assign addr_d     = wr_q.rd;
   assign f_alu      = alu_q.f;
   assign illegal    = illegal_q;

   assign unused_bits = ^{inst[14:12], wr_q.f};

endmodule

// File: tb/tb_dp_control.sv
// Self-checking bench for dp_control: write-back scoreboard plus directed
// checks of decode, stalls, counters, illegal pulse and reset discard.
module tb_dp_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready;
   logic [4:0]  addr_a, addr_b, addr_d;
   logic [31:0] imm;
   logic        f, f_alu, wr_regfile, illegal;
   logic [31:0] issued_cnt, stall_cnt;

   dp_control dut (
      .clk        (clk),
      .reset      (reset),
      .inst       (inst),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .addr_a     (addr_a),
      .addr_b     (addr_b),
      .imm        (imm),
      .f          (f),
      .f_alu      (f_alu),
      .addr_d     (addr_d),
      .wr_regfile (wr_regfile),
      .illegal    (illegal),
      .issued_cnt (issued_cnt),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [4:0] rd;
   } exp_t;
   exp_t sb[$];

   int n_vec = 0;
   int n_err = 0;
   int exp_issued = 0;
   int exp_stall  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic logic [31:0] addi(input int rd, input int rs1, input logic [11:0] im);
      logic [4:0] d, s;
      d = 5'(rd);
      s = 5'(rs1);
      return {im, s, 3'b000, d, 7'b0010011};
   endfunction

   function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
      logic [4:0] d, s, t;
      d = 5'(rd);
      s = 5'(rs1);
      t = 5'(rs2);
      return {7'b0, t, s, 3'b000, d, 7'b0110011};
   endfunction

   // Write-back monitor: each cycle either the scoreboard head is due or no write may occur.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         check("wr_en", 32'(wr_regfile), 32'd1);
         check("wr_addr", 32'(addr_d), 32'(sb[0].rd));
         void'(sb.pop_front());
      end else begin
         check("no_wr", 32'(wr_regfile), 32'd0);
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic send(input logic [31:0] w, input int exp_stalls, input int exp_rd);
      int st;
      st = 0;
      inst       = w;
      inst_valid = 1'b1;
      #1;
      while (!inst_ready && st < 10) begin
         st++;
         @(posedge clk);
         #1;
      end
      check("stall_cycles", 32'(st), 32'(exp_stalls));
      if (exp_rd != 0)
         sb.push_back('{cyc + 2, 5'(exp_rd)});
      exp_issued++;
      exp_stall += exp_stalls;
      @(posedge clk);
      #1;
      inst_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      inst_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      inst       = '0;
      inst_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("rst_wr", 32'(wr_regfile), 32'd0);
      check("rst_issued", issued_cnt, 32'd0);
      check("rst_stall", stall_cnt, 32'd0);
      check("rst_ready", 32'(inst_ready), 32'd1);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_f_alu", 32'(f_alu), 32'd0);
      idle(1);

      // ADDI x1,x0,5: decode then one-cycle-later f_alu, write at N+2.
      inst = addi(1, 0, 12'd5);
      #1;
      check("dec_f", 32'(f), 32'd1);
      check("dec_imm", imm, 32'd5);
      check("dec_addr_a", 32'(addr_a), 32'd0);
      send(addi(1, 0, 12'd5), 0, 1);
      check("f_alu", 32'(f_alu), 32'd1);
      idle(3);

      // RAW on rs1: two stall cycles, then ADD issues.
      send(addi(1, 0, 12'd5), 0, 1);
      send(add(2, 1, 1), 2, 2);
      check("f_alu_add", 32'(f_alu), 32'd0);
      check("stall_cnt", stall_cnt, 32'(exp_stall));
      idle(3);

      // rd = x0 never writes and never creates a hazard.
      send(addi(0, 0, 12'd7), 0, 0);
      send(add(3, 0, 0), 0, 3);
      idle(3);

      // ADDI imm bits alias rs2 but must not stall; ADD rs2 hazard from WR stage only.
      send(addi(6, 0, 12'd1), 0, 6);
      send(addi(7, 0, 12'd6), 0, 7);
      send(add(8, 0, 6), 1, 8);
      idle(3);

      // Negative immediate sign extension.
      inst = addi(4, 0, 12'hFFF);
      #1;
      check("imm_sext", imm, 32'hFFFF_FFFF);
      send(addi(4, 0, 12'hFFF), 0, 4);
      idle(3);

      // Illegal opcode: accepted, pulses illegal once, no write.
      send(32'h0000_007F, 0, 0);
      check("illegal_pulse", 32'(illegal), 32'd1);
      check("issued_cnt", issued_cnt, 32'(exp_issued));
      @(posedge clk);
      #1;
      check("illegal_clear", 32'(illegal), 32'd0);
      idle(3);

      // ADDI x5, then reset one cycle later: in-flight write discarded.
      send(addi(5, 0, 12'd3), 0, 0);
      reset = 1'b0;
      #1;
      check("rst_async_issued", issued_cnt, 32'd0);
      check("rst_async_fa", 32'(f_alu), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      exp_issued = 0;
      exp_stall  = 0;
      idle(1);

      send(addi(9, 0, 12'd1), 0, 9);
      idle(4);
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("final_issued", issued_cnt, 32'(exp_issued));
      check("final_stall", stall_cnt, 32'(exp_stall));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dp_control.md
Name: dp_control

Overview:
- Control unit that drives the control side of the 3-stage register/ALU datapath (DEC -> ALU -> WR).
- Accepts 32-bit instructions over a valid/ready handshake and decodes them into register addresses, immediate and function select.
- Delays write-back control so it lines up with the write-back stage.
- Detects read-after-write hazards and stalls, because the datapath has no bypass and the register file has no write-through.

Parameters:
- LENGTH, 32, data/instruction width.
- NREGS, 32, number of architectural registers.
- SEL_BITS, $clog2(NREGS), register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst  in  LENGTH  instruction word.
- inst_valid  in  1  inst is valid.
- inst_ready  out  1  block accepts inst this cycle.
- addr_a  out  SEL_BITS  DEC-stage source A (inst[19:15]).
- addr_b  out  SEL_BITS  DEC-stage source B (inst[24:20]).
- imm  out  LENGTH  sign-extended inst[31:20].
- f  out  1  DEC-stage operand select: 1 = immediate, 0 = register.
- f_alu  out  1  f of the instruction currently in the ALU stage.
- addr_d  out  SEL_BITS  destination of the instruction in the WR stage.
- wr_regfile  out  1  register-file write enable for the WR stage.
- illegal  out  1  one-cycle pulse: an unsupported opcode was accepted.
- issued_cnt  out  32  instructions accepted (legal and illegal).
- stall_cnt  out  32  cycles with inst_valid=1 and inst_ready=0.

Behaviour:
- Opcode inst[6:0]:
  - 7'b0110011 = ADD (f=0, writes rd = inst[11:7]).
  - 7'b0010011 = ADDI (f=1, writes rd).
  - Anything else is illegal: accepted, causes no write, pulses illegal the following cycle.
- DEC outputs (addr_a, addr_b, imm, f) are combinational from inst every cycle, regardless of valid.
- Issue: transfer occurs when inst_valid && inst_ready. The issuing instruction enters pipe stage ALU at the next edge.
- Pipe registers: stage ALU and stage WR. Each holds {v, rd, f}, where v = "will write".
  - Every edge, WR <= ALU.
  - ALU <= issued entry, or a bubble (v=0) when there is no transfer.
  - An entry with rd == 0 has v forced to 0; x0 is never written.
- Outputs from the pipe: wr_regfile = WR.v, addr_d = WR.rd, f_alu = ALU.f.
  - Net latency: an instruction accepted in cycle N asserts wr_regfile in cycle N+2.
- Hazard: for a legal inst, a source counts as used when:
  - rs1 is used by both ADD and ADDI;
  - rs2 is used only by ADD.
- hazard = inst_valid && legal && some used source s != 0 with (ALU.v && ALU.rd == s) or (WR.v && WR.rd == s).
- inst_ready = !hazard. It is combinational on inst. The sender must not make inst_valid depend on inst_ready.
- A stall inserts bubbles and drains in at most 2 cycles. After a stall, issue resumes with the same inst held by the sender.
- Counters wrap modulo 2^32 with no saturation.
- Reset (asynchronous assert, synchronous deassert by the system):
  - all pipe v = 0, rd = 0, f = 0;
  - wr_regfile = 0, addr_d = 0, f_alu = 0, illegal = 0;
  - both counters = 0.
- Reset mid-operation discards in-flight writes. No write-back occurs after reset asserts.
- inst_valid=0 produces no stall count, no hazard, and a bubble issue.

Decomposition:
- Package dp_ctrl_pkg holds:
  - opcode constants OP_ADD and OP_ADDI;
  - field position localparams;
  - typedef stage_t {v, rd, f};
  - function sext12.
- Sub-module dp_hazard_unit: combinational compare of the DEC sources against the ALU and WR stages, producing hazard.
- The pipe registers, handshake and counters stay in dp_control.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> wr_regfile=0, issued_cnt=0, stall_cnt=0, inst_ready=1 with valid=0.
- ADDI x1,x0,5 accepted at cycle N -> f=1 and imm=5 at N; f_alu=1 at N+1; wr_regfile=1 with addr_d=1 at N+2 only.
- ADDI x1,x0,5 then ADD x2,x1,x1 held valid -> inst_ready=0 for 2 cycles, stall_cnt=2, ADD accepted at N+3, wr addr_d=2 at N+5.
- ADDI x0,x0,7 then ADD x3,x0,x0 -> no stall, and wr_regfile never asserts for rd=0.
- ADDI x4 with imm=12'hFFF -> imm=32'hFFFFFFFF. Then opcode 7'h7F -> accepted, illegal=1 one cycle later, no write, issued_cnt incremented.
- ADDI x5 accepted, then reset asserted one cycle later -> wr_regfile stays 0 and no write to x5 occurs.
